mar_ctrl_seq: RTL and testbench
===============================

# mar_ctrl_seq

Instruction sequencer for the SAP-style datapath built around the 4-bit memory address register. It runs a one-hot T-state ring counter with six states (T1..T6) and decodes the current state and the instruction opcode into the datapath control word. The control word covers the MAR load enables (g1/g2), the MAR source select, and the PC, RAM, IR, accumulator, ALU, B-register and output-register strobes. It supports free-run and single-step operation and latches a halt.

## Interface
Parameters:
- OP_LDA, 4'h0, load accumulator opcode
- OP_ADD, 4'h1, add opcode
- OP_SUB, 4'h2, subtract opcode
- OP_OUT, 4'hE, output opcode
- OP_HLT, 4'hF, halt opcode

Ports:
- clk  in  1  rising-edge clock, single clock domain
- clr  in  1  synchronous, active-high reset
- run  in  1  level; 1 = advance one T-state every clock
- step  in  1  single-step request; a rising edge advances one T-state while run=0
- opcode  in  4  IR[7:4]; valid from T4 onward
- t_state  out  6  one-hot state; bit0 = T1 … bit5 = T6
- mar_sel  out  2  MAR source: 00 = PC, 01 = IR operand; 10/11 never driven
- mar_g1, mar_g2  out  1 each  MAR load enables; MAR loads only when both are 1
- ep  out  1  PC drives bus
- cp  out  1  PC increment
- ce  out  1  RAM drives bus
- li  out  1  IR load
- ei  out  1  IR operand drives bus
- la  out  1  accumulator load
- ea  out  1  accumulator drives bus
- su  out  1  ALU subtract select
- eu  out  1  ALU drives bus
- lb  out  1  B register load
- lo  out  1  output register load
- halted  out  1  halt latched

## Operation
Registers:
- t_state: one-hot, reset value 000001 (T1).
- halted: reset value 0.
- step_q: delayed copy of step, reset value 0.

Advance control:
- step_rise = step & ~step_q.
- adv = ~halted & (run | step_rise).
- When run=1, step is ignored (at most one advance per clock).

Transitions, taken on adv only:
- T1→T2→T3→T4 for every opcode.
- At T4: LDA/ADD/SUB → T5; HLT → set halted, t_state stays T4; OUT and undefined opcodes → T1.
- At T5: LDA → T1; ADD/SUB → T6.
- T6 → T1.

Control decode is combinational from t_state and opcode. Every output not listed for a state is 0; mar_sel defaults to 00.
- T1: ep, mar_g1, mar_g2 with mar_sel=00 (MAR ← PC).
- T2: cp.
- T3: ce, li.
- T4, LDA/ADD/SUB: ei, mar_g1, mar_g2 with mar_sel=01 (MAR ← IR[3:0]).
- T4, OUT: ea, lo.
- T4, HLT or undefined opcode: nothing asserted.
- T5, LDA: ce, la.
- T5, ADD/SUB: ce, lb.
- T6, ADD: eu, la.
- T6, SUB: eu, su, la.

Halt behaviour:
- While halted=1, every control output is 0 and t_state is frozen at 001000.
- run and step are ignored; only clr exits the halt.

## Timing
- State update occurs on the rising clk edge when adv=1. Control outputs follow t_state in the same cycle (zero added latency).
- Instruction lengths in free-run: OUT/NOP 4 cycles, LDA 5, ADD/SUB 6.
- Step: the edge at which step is first sampled high advances the state. Holding step high gives exactly one advance, because step_q suppresses the rest.
- clr has priority over everything. Mid-instruction it forces T1, halted=0, step_q=0 on the next edge; outputs then show the T1 control word.
- clr and step asserted together: reset wins, and the step edge is consumed (step_q←0 means a still-high step on the following cycle produces a new rising edge).
- opcode changes during T1–T3 have no effect on outputs.
- opcode is sampled combinationally at T4/T5/T6 and must be stable across the full cycle.

## Test plan
1. Reset: hold clr=1 for 2 cycles with run=1 → t_state=000001, halted=0, ep=mar_g1=mar_g2=1, mar_sel=00, all other outputs 0.
2. LDA free-run: opcode=0, run=1 → t_state cycles T1..T5 then T1 (5-cycle period). At T4: ei=1, mar_sel=01, mar_g1=mar_g2=1. At T5: ce=la=1.
3. ADD/SUB: opcode=1, then 2 → 6-cycle period. At T5: ce=lb=1. At T6: ADD gives eu=la=1, su=0; SUB gives eu=su=la=1.
4. OUT/undefined: opcode=E → T4 shows ea=lo=1 and the next state is T1. opcode=7 → T4 all outputs 0, and the period is 4 cycles.
5. HLT: opcode=F, run=1 → after the T4 edge, halted=1, t_state=001000, all control outputs 0 for 10 cycles, including while step is toggled. Then clr=1 → T1, halted=0.
6. Single-step and mid-reset: run=0, step held high for 5 cycles → exactly one advance (T1→T2). Three separate 1-cycle pulses → T2→T5 (LDA). Assert clr at T5 → T1 on the next edge.

Source files
------------

// File: rtl/mar_ctrl_seq.sv
// SAP-style instruction sequencer: six-state one-hot T-ring plus
// control-word decode for the 4-bit MAR datapath.
module mar_ctrl_seq #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic [1:0] mar_sel,
    output logic       mar_g1,
    output logic       mar_g2,
    output logic       ep,
    output logic       cp,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       halted
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e state;
    logic    step_q;
    logic    step_rise;
    logic    adv;
    logic    is_lda;
    logic    is_arith;
    logic    is_mem;
    logic    is_out;
    logic    is_hlt;

    assign step_rise = step & ~step_q;
    assign adv       = ~halted & (run | step_rise);

    assign is_lda   = (opcode == OP_LDA);
    assign is_arith = (opcode == OP_ADD) | (opcode == OP_SUB);
    assign is_mem   = is_lda | is_arith;
    assign is_out   = (opcode == OP_OUT);
    assign is_hlt   = (opcode == OP_HLT);

    // step_q is cleared by clr so a step held through reset re-arms.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= T1;
            halted <= 1'b0;
            step_q <= 1'b0;
        end else begin
            step_q <= step;
            if (adv) begin
                case (state)
                    T1: state <= T2;
                    T2: state <= T3;
                    T3: state <= T4;
                    T4: begin
                        if (is_mem)
                            state <= T5;
                        else if (is_hlt)
                            halted <= 1'b1;
                        else
                            state <= T1;
                    end
                    T5: state <= is_arith ? T6 : T1;
                    T6: state <= T1;
                    default: state <= T1;
                endcase
            end
        end
    end

    assign t_state = state;

    always_comb begin
        mar_sel = 2'b00;
        mar_g1  = 1'b0;
        mar_g2  = 1'b0;
        ep      = 1'b0;
        cp      = 1'b0;
        ce      = 1'b0;
        li      = 1'b0;
        ei      = 1'b0;
        la      = 1'b0;
        ea      = 1'b0;
        su      = 1'b0;
        eu      = 1'b0;
        lb      = 1'b0;
        lo      = 1'b0;
        if (!halted) begin
            case (state)
                T1: begin
                    ep     = 1'b1;
                    mar_g1 = 1'b1;
                    mar_g2 = 1'b1;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                T4: begin
                    if (is_mem) begin
                        ei      = 1'b1;
                        mar_sel = 2'b01;
                        mar_g1  = 1'b1;
                        mar_g2  = 1'b1;
                    end else if (is_out) begin
                        ea = 1'b1;
                        lo = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        ce = 1'b1;
                        la = 1'b1;
                    end else if (is_arith) begin
                        ce = 1'b1;
                        lb = 1'b1;
                    end
                end
                T6: begin
                    if (is_arith) begin
                        eu = 1'b1;
                        la = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mar_ctrl_seq.sv
// Directed plus random checks of mar_ctrl_seq against an
// instruction-level model (phase number and instruction length).
module tb_mar_ctrl_seq;

    logic       clk;
    logic       clr;
    logic       run;
    logic       step;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic [1:0] mar_sel;
    logic       mar_g1, mar_g2, ep, cp, ce, li, ei;
    logic       la, ea, su, eu, lb, lo, halted;

    int nasserts = 0;
    int nfail    = 0;

    int ph   = 1;
    bit mh   = 0;
    bit msq  = 0;

    mar_ctrl_seq dut (
        .clk(clk), .clr(clr), .run(run), .step(step),
        .opcode(opcode), .t_state(t_state), .mar_sel(mar_sel),
        .mar_g1(mar_g1), .mar_g2(mar_g2), .ep(ep), .cp(cp),
        .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea), .su(su),
        .eu(eu), .lb(lb), .lo(lo), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ilen(input logic [3:0] op);
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
    endfunction

    // {mar_sel, g1, g2, ep, cp, ce, li, ei, la, ea, su, eu, lb, lo}
    function automatic logic [14:0] exp_ctrl(input int p,
                                             input logic [3:0] op,
                                             input bit h);
        logic [14:0] w;
        bit mem;
        w = '0;
        mem = (op <= 4'h2);
        if (!h) begin
            case (p)
                1: begin w[12] = 1; w[11] = 1; w[10] = 1; end
                2: w[9] = 1;
                3: begin w[8] = 1; w[7] = 1; end
                4: begin
                    if (mem) begin
                        w[13] = 1; w[12] = 1; w[11] = 1; w[6] = 1;
                    end else if (op == 4'hE) begin
                        w[4] = 1; w[0] = 1;
                    end
                end
                5: begin
                    w[8] = 1;
                    if (op == 4'h0) w[5] = 1;
                    else w[1] = 1;
                end
                6: begin
                    w[2] = 1; w[5] = 1;
                    w[3] = (op == 4'h2);
                end
                default: ;
            endcase
        end
        return w;
    endfunction

    function automatic void model_edge(input bit c, input bit r,
                                       input bit s,
                                       input logic [3:0] op);
        bit adv;
        if (c) begin
            ph = 1; mh = 0; msq = 0;
            return;
        end
        adv = !mh && (r || (s && !msq));
        msq = s;
        if (!adv) return;
        if (ph == 4 && op == 4'hF) mh = 1;
        else if (ph >= ilen(op)) ph = 1;
        else ph = ph + 1;
    endfunction

    task automatic check(input string tag);
        logic [14:0] ctl;
        logic [14:0] ex;
        logic [5:0]  ts;
        ctl = {mar_sel, mar_g1, mar_g2, ep, cp, ce, li, ei,
               la, ea, su, eu, lb, lo};
        ex = exp_ctrl(ph, opcode, mh);
        ts = 6'b1 << (ph - 1);
        nasserts++;
        assert (t_state === ts) else begin
            nfail++;
            $error("FAIL %s t_state obs=%b exp=%b", tag, t_state, ts);
        end
        nasserts++;
        assert (halted === mh) else begin
            nfail++;
            $error("FAIL %s halted obs=%b exp=%b", tag, halted, mh);
        end
        nasserts++;
        assert (ctl === ex) else begin
            nfail++;
            $error("FAIL %s ctrl obs=%b exp=%b", tag, ctl, ex);
        end
    endtask

    task automatic cyc(input bit c, input bit r, input bit s,
                       input logic [3:0] op, input string tag);
        clr = c; run = r; step = s; opcode = op;
        @(posedge clk);
        #1;
        model_edge(c, r, s, op);
        check(tag);
    endtask

    initial begin
        clr = 1; run = 1; step = 0; opcode = 4'h0;

        cyc(1, 1, 0, 4'h0, "reset0");
        cyc(1, 1, 0, 4'h0, "reset1");

        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 4'h0, "lda");
        cyc(1, 0, 0, 4'h1, "rst_add");
        for (int i = 0; i < 13; i++) cyc(0, 1, 0, 4'h1, "add");
        cyc(1, 0, 0, 4'h2, "rst_sub");
        for (int i = 0; i < 13; i++) cyc(0, 1, 0, 4'h2, "sub");
        cyc(1, 0, 0, 4'hE, "rst_out");
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 4'hE, "out");
        cyc(1, 0, 0, 4'h7, "rst_nop");
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 4'h7, "nop");

        cyc(1, 0, 0, 4'hF, "rst_hlt");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'hF, "hlt_run");
        for (int i = 0; i < 10; i++)
            cyc(0, i % 3 != 0, i[0], 4'hF, "hlt_hold");
        cyc(1, 1, 1, 4'hF, "hlt_clr");

        cyc(1, 0, 0, 4'h0, "rst_step");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'h0, "step_hold");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 4'h0, "step_low");
            cyc(0, 0, 1, 4'h0, "step_pulse");
        end
        cyc(0, 0, 0, 4'h0, "step_t5");
        cyc(1, 0, 1, 4'h0, "clr_step");
        cyc(0, 0, 1, 4'h0, "step_after_clr");

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            bit c;
            op = opcode;
            if (ph <= 3 && !mh) op = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 39) == 0);
            cyc(c, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                op, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasserts, nfail);
        $finish;
    end

endmodule
